// File: rtl/mcu_bus_pkg.sv
// Shared types and helpers for the MCU parallel-bus slave.
package mcu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_HOLD   = 3'd1,
    WR_COMMIT = 3'd2,
    RD_SEL    = 3'd3,
    RD_WAIT   = 3'd4,
    RD_DRIVE  = 3'd5,
    RECOVER   = 3'd6
  } bus_state_t;

  localparam int DEFAULT_SYNC = 2;

  // An address selects a module only if it indexes one of the n modules,
  // i.e. every bit above the module index is zero (and the index is < n).
  function automatic logic idx_valid(input logic [31:0] addr, input logic [31:0] n);
    return (addr < n);
  endfunction

endpackage

// File: rtl/mcu_bus_if.sv
// MCU-side pins of the FSMC-style async parallel bus.
interface mcu_bus_if #(
  parameter int AW    = 8,
  parameter int WIDTH = 16
);
  logic             mcu_ne;
  logic             mcu_noe;
  logic             mcu_nwe;
  logic [AW-1:0]    mcu_addr;
  logic [WIDTH-1:0] mcu_data_in;
  logic [WIDTH-1:0] mcu_data_out;
  logic             mcu_data_oe;

  modport master (
    output mcu_ne, mcu_noe, mcu_nwe, mcu_addr, mcu_data_in,
    input  mcu_data_out, mcu_data_oe
  );

  modport slave (
    input  mcu_ne, mcu_noe, mcu_nwe, mcu_addr, mcu_data_in,
    output mcu_data_out, mcu_data_oe
  );
endinterface

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser; resets to 1 so idle active-low strobes
// never look asserted coming out of reset.
module sync_ff #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] sync_q;
  logic [SYNC-1:0] sync_d;

  // Shift the asynchronous input one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[SYNC-2:0], d};
  end

  // Synchroniser chain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC{1'b1}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC-1];

endmodule

// File: rtl/mcu_bus_slave.sv
// MCU async parallel-bus slave: synchronises the strobes, decodes the address
// into one-hot write/read strobes and returns the muxed read data to the pads.
// All outputs are registered; each transition computes the outputs that must
// be visible while the FSM sits in the state being entered.
module mcu_bus_slave
  import mcu_bus_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int AW    = 8,
  parameter int SYNC  = DEFAULT_SYNC
) (
  input  logic                 clk,
  input  logic                 reset,
  mcu_bus_if.slave             mcu,
  output logic [$clog2(N)-1:0] cs_addr,
  input  logic [WIDTH-1:0]     rd_data,
  output logic [WIDTH-1:0]     wr_data,
  output logic [N-1:0]         wr_en,
  output logic [N-1:0]         rd_en,
  output logic                 bus_err
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE_HOT_BASE = {{(N-1){1'b0}}, 1'b1};

  logic ne_s, noe_s, nwe_s;

  sync_ff #(.SYNC(SYNC)) u_sync_ne  (.clk(clk), .rst_n(reset), .d(mcu.mcu_ne),  .q(ne_s));
  sync_ff #(.SYNC(SYNC)) u_sync_noe (.clk(clk), .rst_n(reset), .d(mcu.mcu_noe), .q(noe_s));
  sync_ff #(.SYNC(SYNC)) u_sync_nwe (.clk(clk), .rst_n(reset), .d(mcu.mcu_nwe), .q(nwe_s));

  bus_state_t       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    cs_addr_q, cs_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [N-1:0]     wr_en_q, wr_en_d;
  logic [N-1:0]     rd_en_q, rd_en_d;
  logic             bus_err_q, bus_err_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             oe_q, oe_d;
  logic             rd_err_q, rd_err_d;

  // Address is held stable by the MCU, so it may be decoded straight from the pins.
  logic          pin_valid;
  logic [IW-1:0] pin_idx;
  assign pin_valid = idx_valid(32'(mcu.mcu_addr), 32'(N));
  assign pin_idx   = mcu.mcu_addr[IW-1:0];

  // Next-state and registered-output logic of the bus FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cs_addr_d  = cs_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = {N{1'b0}};
    rd_en_d    = {N{1'b0}};
    bus_err_d  = 1'b0;
    data_out_d = data_out_q;
    oe_d       = oe_q;
    rd_err_d   = rd_err_q;
    case (state_q)
      IDLE: begin
        if (!ne_s && !noe_s && !nwe_s) begin
          bus_err_d = 1'b1;
          state_d   = RECOVER;
        end else if (!ne_s && !nwe_s) begin
          addr_d  = mcu.mcu_addr;
          data_d  = mcu.mcu_data_in;
          state_d = WR_HOLD;
        end else if (!ne_s && !noe_s) begin
          addr_d  = mcu.mcu_addr;
          oe_d    = 1'b1;
          state_d = RD_SEL;
          if (pin_valid) begin
            cs_addr_d = pin_idx;
            rd_en_d   = ONE_HOT_BASE << pin_idx;
            rd_err_d  = 1'b0;
          end else begin
            // Unmapped read: keep cs_addr, no pop, return zeros.
            bus_err_d = 1'b1;
            rd_err_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_HOLD: begin
        if (ne_s && !nwe_s) begin
          // Chip select dropped before the write strobe: discard the write.
          state_d = IDLE;
        end else if (nwe_s) begin
          state_d = WR_COMMIT;
          if (idx_valid(32'(addr_q), 32'(N))) begin
            wr_en_d   = ONE_HOT_BASE << addr_q[IW-1:0];
            wr_data_d = data_q;
          end else begin
            bus_err_d = 1'b1;
          end
        end else begin
          data_d = mcu.mcu_data_in;
        end
      end
      WR_COMMIT: begin
        state_d = IDLE;
      end
      RD_SEL: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // The mux register now holds the selected module's data.
        state_d    = RD_DRIVE;
        data_out_d = rd_err_q ? {WIDTH{1'b0}} : rd_data;
      end
      RD_DRIVE: begin
        if (noe_s || ne_s) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end else begin
          data_out_d = rd_err_q ? {WIDTH{1'b0}} : rd_data;
        end
      end
      RECOVER: begin
        if (noe_s && nwe_s) begin
          state_d = IDLE;
        end else begin
          state_d = RECOVER;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, latches and output registers; reset drops the pad drive at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= {AW{1'b0}};
      data_q     <= {WIDTH{1'b0}};
      cs_addr_q  <= {IW{1'b0}};
      wr_data_q  <= {WIDTH{1'b0}};
      wr_en_q    <= {N{1'b0}};
      rd_en_q    <= {N{1'b0}};
      bus_err_q  <= 1'b0;
      data_out_q <= {WIDTH{1'b0}};
      oe_q       <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cs_addr_q  <= cs_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      bus_err_q  <= bus_err_d;
      data_out_q <= data_out_d;
      oe_q       <= oe_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign cs_addr          = cs_addr_q;
  assign wr_data          = wr_data_q;
  assign wr_en            = wr_en_q;
  assign rd_en            = rd_en_q;
  assign bus_err          = bus_err_q;
  assign mcu.mcu_data_out = data_out_q;
  assign mcu.mcu_data_oe  = oe_q;

endmodule

// File: tb/tb_mcu_bus_slave.sv
// Self-checking bench for mcu_bus_slave: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mcu_bus_slave;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int AW    = 8;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       cs_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] wr_data;
  logic [N-1:0]     wr_en;
  logic [N-1:0]     rd_en;
  logic             bus_err;

  mcu_bus_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

  mcu_bus_slave #(.N(N), .WIDTH(WIDTH), .AW(AW), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .mcu(bus), .cs_addr(cs_addr), .rd_data(rd_data),
    .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Module register contents seen through the output mux (1-cycle registered).
  logic [WIDTH-1:0] mem [0:N-1];
  always @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[cs_addr];
  end

  // Pulse monitor: counts strobes and records what accompanied them.
  int             wr_pulses = 0, rd_pulses = 0, err_pulses = 0, viol = 0;
  logic [N-1:0]     last_wr_en = '0, last_rd_en = '0;
  logic [WIDTH-1:0] last_wr_data = '0;
  always @(negedge clk) begin
    if (wr_en != '0) begin wr_pulses++; last_wr_en = wr_en; last_wr_data = wr_data; end
    if (rd_en != '0) begin rd_pulses++; last_rd_en = rd_en; end
    if (bus_err) err_pulses++;
    if ((wr_en != '0 && rd_en != '0) || $countones(wr_en) > 1 || $countones(rd_en) > 1) viol++;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pins_idle();
    bus.mcu_ne = 1'b1; bus.mcu_noe = 1'b1; bus.mcu_nwe = 1'b1;
  endtask

  // One MCU write; the data pins change every cycle, the last value must commit.
  task automatic do_write(input logic [7:0] addr, input int hold, input bit abort, input string tag);
    int w0, r0, e0, exp_w, exp_e;
    logic [WIDTH-1:0] d;
    logic [N-1:0] exp_en;
    w0 = wr_pulses; r0 = rd_pulses; e0 = err_pulses;
    exp_w  = (!abort && addr < N) ? 1 : 0;
    exp_e  = (!abort && addr >= N) ? 1 : 0;
    exp_en = (N'(1)) << addr[1:0];
    d = 16'($urandom);
    bus.mcu_addr = addr; bus.mcu_data_in = d; bus.mcu_ne = 1'b0;
    cyc(1);
    bus.mcu_nwe = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cyc(1);
      d = 16'($urandom);
      bus.mcu_data_in = d;
    end
    if (abort) begin
      bus.mcu_ne = 1'b1; cyc(2); bus.mcu_nwe = 1'b1;
    end else begin
      bus.mcu_nwe = 1'b1; cyc(2); bus.mcu_ne = 1'b1;
    end
    cyc(SYNC + 3);
    checks++;
    if (wr_pulses - w0 !== exp_w) begin errors++; $display("FAIL %s wr_pulses got %0d want %0d", tag, wr_pulses - w0, exp_w); end
    checks++;
    if (err_pulses - e0 !== exp_e) begin errors++; $display("FAIL %s bus_err got %0d want %0d", tag, err_pulses - e0, exp_e); end
    checks++;
    if (rd_pulses - r0 !== 0) begin errors++; $display("FAIL %s rd_pulses got %0d want 0", tag, rd_pulses - r0); end
    if (exp_w == 1) begin
      checks++;
      if (last_wr_en !== exp_en) begin errors++; $display("FAIL %s wr_en got %b want %b", tag, last_wr_en, exp_en); end
      checks++;
      if (last_wr_data !== d) begin errors++; $display("FAIL %s wr_data got %h want %h", tag, last_wr_data, d); end
    end
  endtask

  // One MCU read with NOE held low for low_cycles (>= SYNC+3).
  task automatic do_read(input logic [7:0] addr, input int low_cycles, input string tag);
    int w0, r0, e0, exp_r, exp_e;
    logic [WIDTH-1:0] exp_d;
    logic [N-1:0] exp_en;
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    w0 = wr_pulses; r0 = rd_pulses; e0 = err_pulses;
    exp_r  = (addr < N) ? 1 : 0;
    exp_e  = (addr < N) ? 0 : 1;
    exp_d  = (addr < N) ? mem[addr[1:0]] : 16'h0000;
    exp_en = (N'(1)) << addr[1:0];
    bus.mcu_addr = addr; bus.mcu_ne = 1'b0;
    cyc(1);
    bus.mcu_noe = 1'b0;
    cyc(SYNC + 3);
    checks++;
    if (bus.mcu_data_out !== exp_d) begin errors++; $display("FAIL %s data_out at latency got %h want %h", tag, bus.mcu_data_out, exp_d); end
    checks++;
    if (bus.mcu_data_oe !== 1'b1) begin errors++; $display("FAIL %s oe got %b want 1", tag, bus.mcu_data_oe); end
    if (addr < N) begin
      checks++;
      if (cs_addr !== addr[1:0]) begin errors++; $display("FAIL %s cs_addr got %0d want %0d", tag, cs_addr, addr[1:0]); end
    end
    cyc(low_cycles - (SYNC + 3));
    checks++;
    if (bus.mcu_data_out !== exp_d) begin errors++; $display("FAIL %s data_out held got %h want %h", tag, bus.mcu_data_out, exp_d); end
    bus.mcu_noe = 1'b1;
    cyc(SYNC + 1);
    checks++;
    if (bus.mcu_data_oe !== 1'b0) begin errors++; $display("FAIL %s oe release got %b want 0", tag, bus.mcu_data_oe); end
    bus.mcu_ne = 1'b1;
    cyc(2);
    checks++;
    if (rd_pulses - r0 !== exp_r) begin errors++; $display("FAIL %s rd_pulses got %0d want %0d", tag, rd_pulses - r0, exp_r); end
    checks++;
    if (err_pulses - e0 !== exp_e) begin errors++; $display("FAIL %s bus_err got %0d want %0d", tag, err_pulses - e0, exp_e); end
    checks++;
    if (wr_pulses - w0 !== 0) begin errors++; $display("FAIL %s wr_pulses got %0d want 0", tag, wr_pulses - w0); end
    if (exp_r == 1) begin
      checks++;
      if (last_rd_en !== exp_en) begin errors++; $display("FAIL %s rd_en got %b want %b", tag, last_rd_en, exp_en); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pins_idle();
    bus.mcu_addr = '0; bus.mcu_data_in = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    cyc(3);
    checks++;
    if ({wr_en, rd_en, bus_err, cs_addr, wr_data, bus.mcu_data_out, bus.mcu_data_oe} !== '0) begin
      errors++;
      $display("FAIL reset outputs wr_en=%b rd_en=%b err=%b cs=%0d wr_data=%h dout=%h oe=%b want all 0",
               wr_en, rd_en, bus_err, cs_addr, wr_data, bus.mcu_data_out, bus.mcu_data_oe);
    end
    reset = 1'b1;
    cyc(SYNC + 2);
  endtask

  task automatic test_write();
    bus.mcu_addr = 8'd1; bus.mcu_ne = 1'b0; bus.mcu_data_in = 16'hA5A5;
    do_write(8'd1, 6, 1'b0, "write_rand_a1");
    do_write(8'd2, 4, 1'b0, "write_rand_a2");
  endtask

  task automatic test_read();
    do_read(8'd2, 8, "read_a2");
    do_read(8'd0, 6, "read_a0");
  endtask

  task automatic test_out_of_range();
    do_write(8'h05, 5, 1'b0, "oor_write");
    do_read(8'h05, 8, "oor_read");
    do_write(8'h80, 5, 1'b0, "oor_write_hi");
  endtask

  task automatic test_abort();
    do_write(8'd3, 5, 1'b1, "abort_write");
    do_write(8'd0, 5, 1'b0, "after_abort_write");
  endtask

  task automatic test_illegal();
    int w0, r0, e0;
    w0 = wr_pulses; r0 = rd_pulses; e0 = err_pulses;
    bus.mcu_addr = 8'd1; bus.mcu_ne = 1'b0;
    cyc(1);
    bus.mcu_noe = 1'b0; bus.mcu_nwe = 1'b0;
    cyc(5);
    bus.mcu_noe = 1'b1;
    cyc(4);
    bus.mcu_nwe = 1'b1;
    cyc(1);
    bus.mcu_ne = 1'b1;
    cyc(SYNC + 2);
    checks++;
    if (err_pulses - e0 !== 1) begin errors++; $display("FAIL illegal bus_err got %0d want 1", err_pulses - e0); end
    checks++;
    if ((wr_pulses - w0) + (rd_pulses - r0) !== 0) begin
      errors++; $display("FAIL illegal strobes got %0d want 0", (wr_pulses - w0) + (rd_pulses - r0));
    end
    do_read(8'd1, 7, "after_illegal_read");
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom) | 16'h0001;
    bus.mcu_addr = 8'd1; bus.mcu_ne = 1'b0;
    cyc(1);
    bus.mcu_noe = 1'b0;
    cyc(SYNC + 4);
    checks++;
    if (bus.mcu_data_oe !== 1'b1) begin errors++; $display("FAIL midreset pre oe got %b want 1", bus.mcu_data_oe); end
    reset = 1'b0;
    #1;
    checks++;
    if ({wr_en, rd_en, bus_err, cs_addr, wr_data, bus.mcu_data_out, bus.mcu_data_oe} !== '0) begin
      errors++;
      $display("FAIL midreset outputs cs=%0d dout=%h oe=%b wr_data=%h want all 0",
               cs_addr, bus.mcu_data_out, bus.mcu_data_oe, wr_data);
    end
    pins_idle();
    cyc(2);
    reset = 1'b1;
    cyc(SYNC + 2);
    do_read(8'd3, 8, "after_reset_read");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 7) == 0) ? 8'hF3 : 8'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) do_write(a, int'($urandom_range(4, 8)), 1'b0, "rand_write");
      else                           do_read(a, int'($urandom_range(SYNC + 3, 10)), "rand_read");
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL strobe_exclusive violations got %0d want 0", viol); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_abort();
    test_illegal();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
